sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter AHB_DWIDTH, default 32, data width of all wdata/rdata ports.
REQ-002 SHALL have port HCLK, input, 1, clock; all logic is rising-edge.
REQ-003 SHALL have port HRESETN, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have, for N=0,1, port pN_req, input, 1, requester N level request, held until pN_ack.
REQ-005 SHALL have, for N=0,1, port pN_write, input, 1, 1=write, 0=read.
REQ-006 SHALL have, for N=0,1, port pN_size, input, 3, AHB HSIZE encoding.
REQ-007 SHALL have, for N=0,1, port pN_addr, input, 20, byte address.
REQ-008 SHALL have, for N=0,1, port pN_wdata, input, AHB_DWIDTH, write data.
REQ-009 SHALL have, for N=0,1, port pN_ack, output, 1, one-cycle completion pulse to requester N.
REQ-010 SHALL have, for N=0,1, port pN_rdata, output, AHB_DWIDTH, read data; valid while pN_ack=1 after a read.
REQ-011 SHALL have port m_req, output, 1, one-cycle request pulse to the SRAM controller.
REQ-012 SHALL have ports m_write (output, 1), m_size (output, 3), m_addr (output, 20) and m_wdata (output, AHB_DWIDTH), the latched command to the SRAM controller.
REQ-013 SHALL have port m_ack, input, 1, SRAM controller completion pulse.
REQ-014 SHALL have port m_rdata, input, AHB_DWIDTH, SRAM controller read data, valid when m_ack=1.
REQ-015 SHALL have port m_busy, input, 1, SRAM BUSY; no new command is issued while it is high.
REQ-016 SHALL have port grant, output, 1, index of the owning requester; valid outside IDLE.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if m_busy=0 and any pN_req=1, the block SHALL select a winner, latch its write/size/addr/wdata into m_* registers, set grant, and go to ISSUE.
REQ-019 IDLE with m_busy=1 SHALL stay in IDLE and latch nothing, regardless of requests.
REQ-020 ISSUE SHALL drive m_req=1 for exactly that one cycle, then go to WAIT.
REQ-021 WAIT SHALL hold m_* stable and, on m_ack=1, capture m_rdata into p[grant]_rdata and go to RESP.
REQ-022 RESP SHALL drive p[grant]_ack=1 for exactly one cycle, then go to IDLE.
REQ-023 Latency, IDLE request sample to pN_ack: 3 cycles plus the controller's m_req-to-m_ack delay (2 cycles with SramCtrlIf-class controllers, 5 total).
REQ-024 pN_req SHALL be sampled only in IDLE, and pN_* command inputs only on the IDLE winner-select edge; changes elsewhere are ignored.
REQ-025 Arbitration (default): round-robin; a last_grant register updates at RESP; on simultaneous requests the port not in last_grant wins; last_grant resets to 1, so port 0 wins the first tie.
REQ-026 A single requesting port SHALL win regardless of last_grant.
REQ-027 The non-granted pN_ack SHALL stay 0, and its pN_rdata SHALL hold its previous value.
REQ-028 m_ack outside WAIT SHALL be ignored.
REQ-029 An illegal state SHALL recover to IDLE on the next edge with all outputs deasserted.
REQ-030 The block SHALL NOT produce write-after-ack back-to-back reuse: a requester that keeps pN_req high past its ack is treated as a new request at the next IDLE.

Reset
REQ-031 On HRESETN=0, asynchronously: state=IDLE; m_req=0, m_write=0, m_size=0, m_addr=0, m_wdata=0; p0_ack=p1_ack=0; p0_rdata=p1_rdata=0; grant=0; last_grant=1.
REQ-032 Reset asserted in ISSUE, WAIT or RESP SHALL abort the transaction with no ack generated, and a later stray m_ack SHALL be ignored per REQ-028.

Configuration
REQ-033 Macro SRAM_ARB_FIXED_PRI_EN: when defined, port 0 SHALL win whenever p0_req=1 and last_grant SHALL be unused; when undefined, REQ-025 round-robin applies.

Verification
REQ-034 p0 write, addr 0x00010, wdata 0xDEADBEEF, size 3'b010 -> m_req pulse 1 cycle after sample with matching m_* values; p0_ack 1 cycle after m_ack.
REQ-035 p1 read of addr 0x00010 after REQ-034 -> p1_ack with p1_rdata=0xDEADBEEF; p0_ack stays 0.
REQ-036 p0 and p1 requesting continuously, 4 transactions -> grants 0,1,0,1 (round-robin), or 0,0,0,0 with SRAM_ARB_FIXED_PRI_EN.
REQ-037 m_busy=1 for 10 cycles with p0_req=1 -> no m_req; m_req 1 cycle after m_busy falls.
REQ-038 HRESETN pulsed low during WAIT -> all outputs 0 immediately, no pN_ack; the next request is served normally.
REQ-039 m_ack injected in IDLE -> no pN_ack and no state change.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: one command in flight at a time.
// Optional macro SRAM_ARB_FIXED_PRI_EN selects fixed priority (port 0) instead of round-robin.
module sram_req_arbiter #(
  parameter int unsigned AHB_DWIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,

  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [2:0]            p0_size,
  input  logic [19:0]           p0_addr,
  input  logic [AHB_DWIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [AHB_DWIDTH-1:0] p0_rdata,

  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [2:0]            p1_size,
  input  logic [19:0]           p1_addr,
  input  logic [AHB_DWIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [AHB_DWIDTH-1:0] p1_rdata,

  output logic                  m_req,
  output logic                  m_write,
  output logic [2:0]            m_size,
  output logic [19:0]           m_addr,
  output logic [AHB_DWIDTH-1:0] m_wdata,
  input  logic                  m_ack,
  input  logic [AHB_DWIDTH-1:0] m_rdata,
  input  logic                  m_busy,

  output logic                  grant
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic                  grant_q;
  logic                  m_write_q;
  logic [2:0]            m_size_q;
  logic [19:0]           m_addr_q;
  logic [AHB_DWIDTH-1:0] m_wdata_q;
  logic [AHB_DWIDTH-1:0] p0_rdata_q;
  logic [AHB_DWIDTH-1:0] p1_rdata_q;

  logic any_req;
  logic select;
  logic winner;

  assign any_req = p0_req | p1_req;
  // Requests are only looked at in IDLE, and only when the controller can take a command
  assign select  = (state_q == StIdle) & any_req & ~m_busy;

`ifdef SRAM_ARB_FIXED_PRI_EN
  assign winner = ~p0_req;
`else
  logic last_grant_q;

  // On a tie the port that was not served last wins; a lone requester always wins
  always_comb begin
    if (p0_req && p1_req) begin
      winner = ~last_grant_q;
    end else begin
      winner = p1_req;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      last_grant_q <= 1'b1;
    end else if (state_q == StResp) begin
      last_grant_q <= grant_q;
    end
  end
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = select ? StIssue : StIdle;
      StIssue: state_d = StWait;
      StWait:  state_d = m_ack ? StResp : StWait;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: single-cycle strobes decoded from state
  always_comb begin
    m_req  = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StIssue: m_req = 1'b1;
      StWait:  ;
      StResp: begin
        p0_ack = ~grant_q;
        p1_ack = grant_q;
      end
      default: ;
    endcase
  end

  // Command latch: loaded only on the winner-select edge, held through WAIT
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      grant_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 3'b000;
      m_addr_q  <= 20'h0;
      m_wdata_q <= '0;
    end else if (select) begin
      grant_q <= winner;
      if (winner) begin
        m_write_q <= p1_write;
        m_size_q  <= p1_size;
        m_addr_q  <= p1_addr;
        m_wdata_q <= p1_wdata;
      end else begin
        m_write_q <= p0_write;
        m_size_q  <= p0_size;
        m_addr_q  <= p0_addr;
        m_wdata_q <= p0_wdata;
      end
    end
  end

  // Read data capture; the port not granted keeps its last value
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else if ((state_q == StWait) && m_ack) begin
      if (grant_q) begin
        p1_rdata_q <= m_rdata;
      end else begin
        p0_rdata_q <= m_rdata;
      end
    end
  end

  assign grant    = grant_q;
  assign m_write  = m_write_q;
  assign m_size   = m_size_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a two-cycle SRAM controller responder.
module tb_sram_req_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        p0_req, p0_write, p1_req, p1_write;
  logic [2:0]  p0_size, p1_size;
  logic [19:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_req, m_write, m_ack, m_busy, grant;
  logic [2:0]  m_size;
  logic [19:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [logic [19:0]];

  always #5 HCLK = ~HCLK;

  sram_req_arbiter #(.AHB_DWIDTH(32)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .p0_req(p0_req), .p0_write(p0_write), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .m_busy(m_busy),
    .grant(grant)
  );

  // Returns the number of negedges (minus one) until m_req is seen, or -1 on timeout
  task automatic wait_mreq(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge HCLK);
      if (m_req) begin
        n = i;
        break;
      end
    end
  endtask

  // Controller model: called at the negedge where m_req is high; acks two cycles later
  task automatic serve(output logic mreq_wait);
    logic w;
    logic [19:0] a;
    logic [31:0] d;
    w = m_write;
    a = m_addr;
    d = m_wdata;
    @(negedge HCLK);
    mreq_wait = m_req;
    @(negedge HCLK);
    m_ack = 1'b1;
    if (w) begin
      mem[a] = d;
      m_rdata = 32'h0;
    end else begin
      m_rdata = mem.exists(a) ? mem[a] : 32'h0;
    end
    @(negedge HCLK);
    m_ack = 1'b0;
    m_rdata = 32'h0BADF00D;
  endtask

  task automatic test_reset();
    HRESETN = 1'b0;
    repeat (2) @(negedge HCLK);
    tests++; if ({m_req, m_write, m_size} !== 5'b0) begin fails++;
      $display("FAIL reset_mcmd: got %b required 0", {m_req, m_write, m_size}); end
    tests++; if ({m_addr, m_wdata} !== 52'h0) begin fails++;
      $display("FAIL reset_maddr_wdata: got %h required 0", {m_addr, m_wdata}); end
    tests++; if ({p0_ack, p1_ack, grant} !== 3'b0) begin fails++;
      $display("FAIL reset_ack_grant: got %b required 000", {p0_ack, p1_ack, grant}); end
    tests++; if ({p0_rdata, p1_rdata} !== 64'h0) begin fails++;
      $display("FAIL reset_rdata: got %h required 0", {p0_rdata, p1_rdata}); end
    HRESETN = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_write_p0();
    int n;
    logic mw;
    p0_write = 1'b1; p0_size = 3'b010; p0_addr = 20'h00010; p0_wdata = 32'hDEADBEEF;
    p0_req = 1'b1;
    wait_mreq(20, n);
    tests++; if (n !== 0) begin fails++;
      $display("FAIL wr_latency: got %0d required 0", n); end
    tests++; if ({grant, m_write, m_size, m_addr} !== {1'b0, 1'b1, 3'b010, 20'h00010}) begin
      fails++; $display("FAIL wr_mcmd: got %h required %h", {grant, m_write, m_size, m_addr},
                        {1'b0, 1'b1, 3'b010, 20'h00010}); end
    tests++; if (m_wdata !== 32'hDEADBEEF) begin fails++;
      $display("FAIL wr_mwdata: got %h required deadbeef", m_wdata); end
    p0_wdata = 32'h11111111; // must not disturb the latched command
    if (n >= 0) begin
      serve(mw);
      tests++; if (mw !== 1'b0) begin fails++;
        $display("FAIL wr_mreq_one_cycle: got %b required 0", mw); end
      tests++; if ({p0_ack, p1_ack} !== 2'b10) begin fails++;
        $display("FAIL wr_ack: got %b required 10", {p0_ack, p1_ack}); end
    end
    p0_req = 1'b0;
    @(negedge HCLK);
    tests++; if (p0_ack !== 1'b0) begin fails++;
      $display("FAIL wr_ack_pulse: got %b required 0", p0_ack); end
  endtask

  task automatic test_read_p1();
    int n;
    logic mw;
    p1_write = 1'b0; p1_size = 3'b010; p1_addr = 20'h00010; p1_wdata = 32'h0;
    p1_req = 1'b1;
    wait_mreq(20, n);
    tests++; if ({n == 0, grant, m_write} !== 3'b110) begin fails++;
      $display("FAIL rd_issue: got lat %0d grant %b write %b required 0 1 0", n, grant, m_write);
    end
    if (n >= 0) begin
      serve(mw);
      tests++; if ({p0_ack, p1_ack} !== 2'b01) begin fails++;
        $display("FAIL rd_ack: got %b required 01", {p0_ack, p1_ack}); end
      tests++; if (p1_rdata !== 32'hDEADBEEF) begin fails++;
        $display("FAIL rd_data: got %h required deadbeef", p1_rdata); end
      tests++; if (p0_rdata !== 32'h0) begin fails++;
        $display("FAIL rd_other_hold: got %h required 0", p0_rdata); end
    end
    p1_req = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_round_robin();
    int n;
    logic mw;
    logic [3:0] exp_g, got_g;
`ifdef SRAM_ARB_FIXED_PRI_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010; // grant of txn k in bit k: 0,1,0,1
`endif
    got_g = 4'b1111;
    p0_write = 1'b1; p0_addr = 20'h00100; p0_wdata = 32'hA0A0A0A0;
    p1_write = 1'b1; p1_addr = 20'h00200; p1_wdata = 32'hB1B1B1B1;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_mreq(20, n);
      if (n < 0) begin
        tests++; fails++; $display("FAIL rr_timeout: txn %0d got no m_req", k);
        break;
      end
      got_g[k] = grant;
      serve(mw);
      tests++; if ({p1_ack, p0_ack} !== (grant ? 2'b10 : 2'b01)) begin fails++;
        $display("FAIL rr_ack: txn %0d got %b", k, {p1_ack, p0_ack}); end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tests++; if (got_g !== exp_g) begin fails++;
      $display("FAIL rr_grants: got %b required %b", got_g, exp_g); end
    @(negedge HCLK);
  endtask

  task automatic test_busy();
    int n, cnt;
    logic mw;
    cnt = 0;
    m_busy = 1'b1;
    p0_write = 1'b0; p0_addr = 20'h00010;
    p0_req = 1'b1;
    repeat (10) begin
      @(negedge HCLK);
      if (m_req) cnt++;
    end
    tests++; if (cnt !== 0) begin fails++;
      $display("FAIL busy_block: got %0d m_req required 0", cnt); end
    m_busy = 1'b0;
    wait_mreq(20, n);
    tests++; if (n !== 0) begin fails++;
      $display("FAIL busy_release: got %0d required 0", n); end
    if (n >= 0) begin
      serve(mw);
      tests++; if ({p0_ack, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++;
        $display("FAIL busy_read: got %b %h required 1 deadbeef", p0_ack, p0_rdata); end
    end
    p0_req = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_stray_ack();
    int n, bad;
    logic mw;
    bad = 0;
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    @(negedge HCLK);
    m_ack = 1'b0; m_rdata = 32'h0BADF00D;
    repeat (2) begin
      if (p0_ack || p1_ack || m_req) bad++;
      @(negedge HCLK);
    end
    tests++; if (bad !== 0) begin fails++;
      $display("FAIL stray_ack_strobe: got %0d bad cycles required 0", bad); end
    tests++; if (p0_rdata !== 32'hDEADBEEF) begin fails++;
      $display("FAIL stray_ack_rdata: got %h required deadbeef", p0_rdata); end
    p0_write = 1'b0; p0_addr = 20'h00100;
    p0_req = 1'b1;
    wait_mreq(20, n);
    tests++; if (n !== 0) begin fails++;
      $display("FAIL stray_ack_idle: got %0d required 0", n); end
    if (n >= 0) begin
      serve(mw);
      tests++; if ({p0_ack, p0_rdata} !== {1'b1, 32'hA0A0A0A0}) begin fails++;
        $display("FAIL stray_ack_next: got %b %h required 1 a0a0a0a0", p0_ack, p0_rdata); end
    end
    p0_req = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_reset_wait();
    int n, bad;
    logic mw;
    bad = 0;
    p1_write = 1'b1; p1_addr = 20'h00020; p1_wdata = 32'h12345678;
    p1_req = 1'b1;
    wait_mreq(20, n);
    @(negedge HCLK); // now in WAIT
    HRESETN = 1'b0;
    #1;
    tests++; if ({m_req, m_write, m_size, m_addr, grant, p0_ack, p1_ack} !== 28'h0) begin
      fails++; $display("FAIL rstwait_ctl: got %h required 0",
                        {m_req, m_write, m_size, m_addr, grant, p0_ack, p1_ack}); end
    tests++; if ({m_wdata, p0_rdata, p1_rdata} !== 96'h0) begin fails++;
      $display("FAIL rstwait_data: got %h required 0", {m_wdata, p0_rdata, p1_rdata}); end
    p1_req = 1'b0;
    @(negedge HCLK);
    HRESETN = 1'b1;
    m_ack = 1'b1; m_rdata = 32'h5A5A5A5A;
    @(negedge HCLK);
    m_ack = 1'b0; m_rdata = 32'h0BADF00D;
    repeat (3) begin
      if (p0_ack || p1_ack || m_req) bad++;
      @(negedge HCLK);
    end
    tests++; if ({bad == 0, p1_rdata} !== {1'b1, 32'h0}) begin fails++;
      $display("FAIL rstwait_stray: got %0d bad cycles rdata %h required 0 0", bad, p1_rdata);
    end
    // First tie after reset goes to port 0, then port 1 is served
    p0_write = 1'b0; p0_addr = 20'h00010;
    p1_write = 1'b0; p1_addr = 20'h00010;
    p0_req = 1'b1; p1_req = 1'b1;
    wait_mreq(20, n);
    tests++; if ({n == 0, grant} !== 2'b10) begin fails++;
      $display("FAIL rst_tie: got lat %0d grant %b required 0 0", n, grant); end
    if (n >= 0) begin
      serve(mw);
      tests++; if ({p0_ack, p1_ack, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin fails++;
        $display("FAIL rst_tie_resp: got %b %h required 10 deadbeef", {p0_ack, p1_ack},
                 p0_rdata); end
    end
    p0_req = 1'b0;
    wait_mreq(20, n);
    tests++; if (grant !== 1'b1 || n < 0) begin fails++;
      $display("FAIL rst_p1_grant: got lat %0d grant %b required 1", n, grant); end
    if (n >= 0) begin
      serve(mw);
      tests++; if ({p1_ack, p1_rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++;
        $display("FAIL rst_p1_resp: got %b %h required 1 deadbeef", p1_ack, p1_rdata); end
    end
    p1_req = 1'b0;
    @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESETN = 1'b0;
    p0_req = 1'b0; p0_write = 1'b0; p0_size = 3'b0; p0_addr = 20'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_write = 1'b0; p1_size = 3'b0; p1_addr = 20'h0; p1_wdata = 32'h0;
    m_ack = 1'b0; m_busy = 1'b0; m_rdata = 32'h0BADF00D;
    test_reset();
    test_write_p0();
    test_read_p1();
    test_round_robin();
    test_busy();
    test_stray_ack();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
